// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 sizes, FSM states and the MEM/WB payload for the memory stage
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, WAIT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] wb_data;
    logic        regwen;
  } memwb_t;
  localparam memwb_t BUBBLE = '0;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the memory stage and the data memory
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores, load extraction/extension and misalignment detect
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        mem_op,
  input  logic        store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        err
);
  logic [31:0] sh;
  logic        illegal;
  logic        misaligned;
  always_comb begin
    illegal = store ? funct3 > F3_W : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = (funct3[1:0] == 2'b01 && offset[0]) || (funct3 == F3_W && offset != 2'b00);
    err = mem_op && (illegal || misaligned);
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    be = !store ? 4'b0000 :
         funct3[1:0] == 2'b00 ? 4'b0001 << offset :
         funct3[1:0] == 2'b01 ? 4'b0011 << offset : 4'b1111;
    sh = rdata >> {offset, 3'b000};
    load_data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_BU ? {24'h0, sh[7:0]} :
                funct3 == F3_HU ? {16'h0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with variable-latency bus, timeout abort and MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        instruction_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        store_data_in,
  input  logic               regwen_in,
  input  logic               memrw_in,
  input  logic               wbsel_in,
  mem_stage_if.master        dmem,
  output logic               stall,
  output logic               misalign_err,
  output logic               bus_err,
  output logic [31:0]        pc_out,
  output logic [31:0]        instruction_out,
  output logic [31:0]        wb_data_out,
  output logic               regwen_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mem_op, err, abort, req;
  logic [31:0]     wdata, load_data, wb_data;
  logic [3:0]      be;
  memwb_t          memwb;
  assign mem_op = memrw_in | wbsel_in;
  load_store_align u_align (
    .funct3     (instruction_in[14:12]),
    .offset     (alu_result_in[1:0]),
    .mem_op     (mem_op),
    .store      (memrw_in),
    .store_data (store_data_in),
    .rdata      (dmem.rdata),
    .wdata      (wdata),
    .be         (be),
    .load_data  (load_data),
    .err        (err)
  );
  always_comb begin
    abort = state == WAIT && cnt == CW'(TIMEOUT_CYCLES);
    req = !reset && !abort && (state == WAIT || (mem_op && !err));
    stall = req && !dmem.ack;
    misalign_err = !reset && state == IDLE && err;
    bus_err = !reset && abort;
    state_nxt = stall ? WAIT : IDLE;
    cnt_nxt = stall ? cnt + CW'(1) : '0;
    wb_data = wbsel_in ? load_data : alu_result_in;
    dmem.req = req;
    dmem.we = req && memrw_in;
    dmem.addr = reset ? 32'h0 : {alu_result_in[31:2], 2'b00};
    dmem.wdata = reset ? 32'h0 : wdata;
    dmem.be = reset ? 4'h0 : be;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      memwb <= BUBBLE;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      memwb <= stall ? BUBBLE : memwb_t'{pc: pc_in, instruction: instruction_in, wb_data: wb_data,
                                         regwen: regwen_in && !err && !abort};
    end
  assign pc_out = memwb.pc;
  assign instruction_out = memwb.instruction;
  assign wb_data_out = memwb.wb_data;
  assign regwen_out = memwb.regwen;
endmodule
